wm_us_echo_gen: RTL and testbench

//  Responder end of the ultrasonic ranging interface: emulates an HC-SR04 sensor.

---
 rtl/wm_us_echo_gen.sv | 114 +++++++++++
 tb/tb_wm_us_echo_gen.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/wm_us_echo_gen.sv
// HC-SR04 ultrasonic sensor emulator: accepts a trigger pulse, waits the burst time,
// then drives echo high for a time proportional to the programmed distance.
module wm_us_echo_gen #(
   parameter int CLK_PER_US     = 125,
   parameter int TRIG_MIN_US    = 10,
   parameter int BURST_US       = 200,
   parameter int ECHO_US_PER_CM = 58,
   parameter int TIMEOUT_US     = 38000,
   parameter int HOLDOFF_US     = 10000
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       trig_in,
   input  logic [7:0] dist_cm,
   output logic       echo_out,
   output logic       busy,
   output logic       trig_err,
   output logic       trig_ignored
);

   localparam int PW = (CLK_PER_US > 1) ? $clog2(CLK_PER_US) : 1;

   typedef enum logic [2:0] {IDLE, TRIG_HI, BURST, ECHO, HOLDOFF} state_t;

   state_t          state, state_nxt;
   logic            trig_s1, trig_s2, trig_d;
   logic [PW-1:0]   presc;
   logic [15:0]     us_cnt;
   logic [15:0]     echo_len;
   logic [16:0]     width_us;
   logic            tick, trig_rise, trig_fall;
   logic            accept, err_nxt, ign_nxt;

   assign tick      = (presc == PW'(CLK_PER_US - 1));
   assign trig_rise = trig_s2 & ~trig_d;
   assign trig_fall = ~trig_s2 & trig_d;
   // Include the tick landing in the fall cycle so an N us pulse measures N us.
   assign width_us  = {1'b0, us_cnt} + {16'd0, tick};

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) state <= IDLE;
      else       state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      err_nxt   = 1'b0;
      ign_nxt   = 1'b0;
      case (state)
         IDLE:    if (trig_rise) state_nxt = TRIG_HI;
         TRIG_HI: begin
            if (trig_fall) begin
               if (width_us >= 17'(TRIG_MIN_US)) begin
                  accept    = 1'b1;
                  state_nxt = BURST;
               end else begin
                  err_nxt   = 1'b1;
                  state_nxt = IDLE;
               end
            end
         end
         BURST: begin
            ign_nxt = trig_rise;
            if (tick && us_cnt == 16'(BURST_US - 1)) state_nxt = ECHO;
         end
         ECHO: begin
            ign_nxt = trig_rise;
            if (tick && us_cnt == echo_len - 16'd1) state_nxt = HOLDOFF;
         end
         HOLDOFF: begin
            ign_nxt = trig_rise;
            if (tick && us_cnt == 16'(HOLDOFF_US - 1)) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outputs are registered from state_nxt, so echo changes on the same edge as the
   // state; this adds one fixed cycle between the sync'd trig fall and the echo rise.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         trig_s1      <= 1'b0;
         trig_s2      <= 1'b0;
         trig_d       <= 1'b0;
         presc        <= '0;
         us_cnt       <= '0;
         echo_len     <= '0;
         echo_out     <= 1'b0;
         busy         <= 1'b0;
         trig_err     <= 1'b0;
         trig_ignored <= 1'b0;
      end else begin
         trig_s1 <= trig_in;
         trig_s2 <= trig_s1;
         trig_d  <= trig_s2;
         if (state_nxt != state || state == IDLE) begin
            presc  <= '0;
            us_cnt <= '0;
         end else begin
            presc <= tick ? '0 : presc + PW'(1);
            if (tick && us_cnt != 16'hFFFF) us_cnt <= us_cnt + 16'd1;
         end
         if (accept)
            echo_len <= (dist_cm == 8'd0) ? 16'(TIMEOUT_US)
                                          : 16'(dist_cm) * 16'(ECHO_US_PER_CM);
         echo_out     <= (state_nxt == ECHO);
         busy         <= (state_nxt != IDLE);
         trig_err     <= err_nxt;
         trig_ignored <= ign_nxt;
      end
   end

endmodule

// File: tb/tb_wm_us_echo_gen.sv
// Self-checking bench for wm_us_echo_gen: a timeline model predicts every output cycle,
// and directed scenarios pin pulse widths and latencies with hand-computed numbers.
module tb_wm_us_echo_gen;

   // Short timeout/holdoff keep the run within a modest cycle count.
   localparam int CPU = 2;
   localparam int MIN = 10;
   localparam int BUR = 200;
   localparam int EPC = 58;
   localparam int TMO = 400;
   localparam int HLD = 100;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       trig_in = 1'b0;
   logic [7:0] dist_cm = 8'd0;
   logic       echo_out, busy, trig_err, trig_ignored;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   wm_us_echo_gen #(
      .CLK_PER_US(CPU), .TRIG_MIN_US(MIN), .BURST_US(BUR),
      .ECHO_US_PER_CM(EPC), .TIMEOUT_US(TMO), .HOLDOFF_US(HLD)
   ) dut (
      .clk(clk), .rstn(rstn), .trig_in(trig_in), .dist_cm(dist_cm),
      .echo_out(echo_out), .busy(busy), .trig_err(trig_err), .trig_ignored(trig_ignored)
   );

   // Timeline model: phase 0 idle, 1 trig high, 2 busy with absolute edge deadlines.
   int k = 0, phase = 0, hk = 0, er_e = 0, ef_e = 0, id_e = 0, mlen = 0;
   bit h0 = 0, h1 = 0, h2 = 0, rise, fall;
   bit m_echo = 0, m_busy = 0, m_err = 0, m_ign = 0;

   initial forever begin
      @(posedge clk);
      k++;
      if (!rstn) begin
         phase = 0; h0 = 0; h1 = 0; h2 = 0;
         m_echo = 0; m_busy = 0; m_err = 0; m_ign = 0;
      end else begin
         rise = h1 && !h2;
         fall = !h1 && h2;
         h2 = h1; h1 = h0; h0 = trig_in;
         m_err = 0; m_ign = 0;
         case (phase)
            0: if (rise) begin phase = 1; hk = k; end
            1: if (fall) begin
                  if ((k - hk) / CPU >= MIN) begin
                     mlen  = (dist_cm == 0) ? TMO : dist_cm * EPC;
                     er_e  = k + BUR * CPU;
                     ef_e  = er_e + mlen * CPU;
                     id_e  = ef_e + HLD * CPU;
                     phase = 2;
                  end else begin
                     m_err = 1; phase = 0;
                  end
               end
            default: begin
               if (rise) m_ign = 1;
               if (k == id_e) phase = 0;
            end
         endcase
         m_echo = (phase == 2) && (k >= er_e) && (k < ef_e);
         m_busy = (phase != 0);
      end
   end

   task automatic cmp(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         if (failures < 40) $display("FAIL %s t=%0t actual=%0d required=%0d", name, $time, act, exp);
      end
   endtask

   // Per-cycle compare plus pulse bookkeeping for the directed checks.
   int run = 0, last_w = 0, n_pulses = 0, n_err = 0, n_ign = 0;
   initial forever begin
      @(negedge clk);
      if (!rstn) begin
         cmp("rst_echo", echo_out, 0); cmp("rst_busy", busy, 0);
         cmp("rst_err", trig_err, 0);  cmp("rst_ign", trig_ignored, 0);
         run = 0;
      end else begin
         cmp("cyc_echo", echo_out, m_echo); cmp("cyc_busy", busy, m_busy);
         cmp("cyc_err", trig_err, m_err);   cmp("cyc_ign", trig_ignored, m_ign);
         if (echo_out) run++;
         else if (run > 0) begin last_w = run; run = 0; n_pulses++; end
         n_err += trig_err;
         n_ign += trig_ignored;
      end
   end

   task automatic trig_pulse(input int us);
      @(negedge clk); trig_in = 1'b1;
      repeat (us * CPU) @(negedge clk);
      trig_in = 1'b0;
   endtask

   task automatic wait_idle(input int maxc);
      int n = 0;
      while (busy && n < maxc) begin @(negedge clk); n++; end
      if (busy) cmp("wait_idle_timeout", 1, 0);
   endtask

   task automatic wait_echo(input bit lvl, input int maxc, output int n);
      n = 0;
      do begin @(negedge clk); n++; end while (echo_out != lvl && n < maxc);
      if (echo_out != lvl) cmp("wait_echo_timeout", echo_out, lvl);
   endtask

   int lat, p0, e0, i0;

   initial begin
      // Reset with trig toggling
      repeat (2) @(negedge clk);
      for (int i = 0; i < 6; i++) begin @(negedge clk); trig_in = ~trig_in; end
      trig_in = 1'b0;
      repeat (3) @(negedge clk);
      cmp("reset_echo", echo_out, 0);
      cmp("reset_busy", busy, 0);
      #2 rstn = 1'b1;
      repeat (5) @(negedge clk);
      cmp("post_reset_busy", busy, 0);

      // dist 10, trig 12 us: 580 us echo, pin fall to echo seen = 3 + BUR*CPU edges
      dist_cm = 8'd10;
      p0 = n_pulses;
      trig_pulse(12);
      wait_echo(1'b1, 2000, lat);
      cmp("rise_latency", lat, 403);
      wait_idle(5000);
      cmp("echo_w_d10", last_w, 1160);
      cmp("pulses_d10", n_pulses - p0, 1);

      // dist 0 -> timeout, dist 255 -> 14790 us
      dist_cm = 8'd0;
      trig_pulse(10);
      wait_echo(1'b1, 2000, lat);
      wait_idle(5000);
      cmp("echo_w_d0", last_w, 800);
      dist_cm = 8'd255;
      trig_pulse(10);
      wait_echo(1'b1, 2000, lat);
      wait_idle(40000);
      cmp("echo_w_d255", last_w, 29580);

      // Short trig rejected
      dist_cm = 8'd20;
      p0 = n_pulses; e0 = n_err;
      trig_pulse(9);
      repeat (10) @(negedge clk);
      cmp("err_count", n_err - e0, 1);
      cmp("short_busy", busy, 0);
      repeat (500) @(negedge clk);
      cmp("short_no_echo", n_pulses - p0, 0);

      // Re-triggers during ECHO and HOLDOFF are ignored; dist change mid-echo no effect
      dist_cm = 8'd10;
      i0 = n_ign;
      trig_pulse(12);
      wait_echo(1'b1, 2000, lat);
      repeat (50) @(negedge clk);
      dist_cm = 8'd200;
      trig_pulse(3);
      wait_echo(1'b0, 3000, lat);
      cmp("echo_w_retrig", last_w, 1160);
      repeat (20) @(negedge clk);
      trig_in = 1'b1;
      wait_idle(1000);
      repeat (20) @(negedge clk);
      cmp("held_trig_no_restart", busy, 0);
      trig_in = 1'b0;
      repeat (5) @(negedge clk);
      cmp("ign_count", n_ign - i0, 2);

      // Reset mid-echo drops echo at once, then a normal 290 us echo
      dist_cm = 8'd100;
      trig_pulse(10);
      wait_echo(1'b1, 2000, lat);
      repeat (100) @(negedge clk);
      cmp("pre_reset_echo", echo_out, 1);
      #2 rstn = 1'b0;
      #1 cmp("async_reset_echo", echo_out, 0);
      cmp("async_reset_busy", busy, 0);
      repeat (3) @(negedge clk);
      #2 rstn = 1'b1;
      dist_cm = 8'd5;
      trig_pulse(10);
      wait_echo(1'b1, 2000, lat);
      cmp("rise_latency_d5", lat, 403);
      wait_idle(3000);
      cmp("echo_w_d5", last_w, 580);

      repeat (5) @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog t=%0t actual=running required=finished", $time);
      $fatal(1, "watchdog expired");
   end

endmodule
